// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core. It holds a word-addressed RAM, a memory-mapped
// cycle counter and a debug FIFO that an external consumer drains over a valid/ready handshake.
module data_mem_responder #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  localparam logic [5:0] OFF_CYCLE = 6'd0;
  localparam logic [5:0] OFF_FIFO  = 6'd1;
  localparam logic [5:0] OFF_CLR   = 6'd2;

  // Address decode
  logic              is_mmio;
  logic [5:0]        mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_en;
  logic              ram_we;
  logic              cycle_we;
  logic              push_req;
  logic              clr_req;
  logic              unused_addr_bits;

  assign is_mmio          = (address_to_mem[31:8] == IO_BASE[31:8]);
  assign mmio_off         = address_to_mem[7:2];
  assign ram_idx          = address_to_mem[RAM_AW+1:2];
  assign unused_addr_bits = ^address_to_mem[1:0];

  // A write presented during reset must not touch any state, RAM included.
  assign wr_en    = WE & ~reset;
  assign ram_we   = wr_en & ~is_mmio;
  assign cycle_we = wr_en & is_mmio & (mmio_off == OFF_CYCLE);
  assign push_req = wr_en & is_mmio & (mmio_off == OFF_FIFO);
  assign clr_req  = wr_en & is_mmio & (mmio_off == OFF_CLR);

  // Data RAM
  logic [31:0] ram_q [RAM_WORDS];

  // NOTE: storage arrays carry no reset; clearing them would cost a write port per word, and
  // their contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= data_to_mem;
    end
  end

  // Cycle counter
  logic [31:0] cycle_q;
  logic [31:0] cycle_d;

  // NOTE: combinational blocks use blocking '=', clocked blocks use non-blocking '<=' so every
  // register samples the pre-edge values of its neighbours.
  always_comb begin
    cycle_d = cycle_we ? data_to_mem : cycle_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  // Debug FIFO
  logic [31:0]        fifo_mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               fifo_full;
  logic               pop;
  logic               push;

  assign fifo_full = (count_q == FULL_COUNT);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
  assign push      = push_req & (~fifo_full | pop);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_req & ~push) begin
      overflow_d = 1'b1;
    end
    if (clr_req) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= data_to_mem;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = fifo_mem_q[rd_ptr_q];
  assign overflow  = overflow_q;

  // Read mux: zero-latency, reads always see pre-edge state.
  always_comb begin
    data_from_mem = '0;
    if (is_mmio) begin
      case (mmio_off)
        OFF_CYCLE: data_from_mem = cycle_q;
        OFF_FIFO:  data_from_mem = {overflow_q, 15'b0, 16'(count_q)};
        default:   data_from_mem = '0;
      endcase
    end else begin
      data_from_mem = ram_q[ram_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a directed vector table, hand sequences for the
// FIFO/overflow/reset corners, then random traffic against a queue-based reference model.
module tb_data_mem_responder;

  localparam int unsigned RAM_WORDS  = 64;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [31:0] IO_BASE    = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  data_mem_responder #(
    .RAM_WORDS (RAM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .IO_BASE   (IO_BASE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .WE            (WE),
    .address_to_mem(address_to_mem),
    .data_to_mem   (data_to_mem),
    .data_from_mem (data_from_mem),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  logic [31:0] m_ram [RAM_WORDS];
  bit          m_vld [RAM_WORDS];
  logic [31:0] m_q [$];
  logic [31:0] m_cycle;
  logic        m_ovf;

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] od;
    logic        ov;
    logic        of;
  } obs_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_io(input logic [31:0] a);
    return (a >> 8) == (IO_BASE >> 8);
  endfunction

  // One bus cycle: inputs driven at posedge+1, outputs compared at the falling edge,
  // then the model steps across the rising edge.
  task automatic do_cycle(input logic rst, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic rdy, output obs_t o);
    logic [31:0] exp_rd;
    bit          rd_known;
    int          idx;
    int          off;
    bit          pop;
    reset          = rst;
    WE             = we;
    address_to_mem = addr;
    data_to_mem    = wd;
    out_ready      = rdy;
    #4;
    o.rd = data_from_mem;
    o.od = out_data;
    o.ov = out_valid;
    o.of = overflow;
    idx  = int'((addr >> 2) % RAM_WORDS);
    off  = int'((addr >> 2) & 32'h3F);
    rd_known = 1'b1;
    exp_rd   = '0;
    if (is_io(addr)) begin
      if (off == 0) exp_rd = m_cycle;
      else if (off == 1) exp_rd = {m_ovf, 15'b0, 16'(m_q.size())};
    end else begin
      rd_known = m_vld[idx];
      exp_rd   = m_ram[idx];
    end
    if (rd_known) check("model rdata", data_from_mem, exp_rd);
    check("model out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("model out_data", out_data, m_q[0]);
    check("model overflow", 32'(overflow), 32'(m_ovf));
    @(posedge clk);
    if (rst) begin
      m_cycle = '0;
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      pop = rdy && (m_q.size() != 0);
      if (we && is_io(addr) && off == 0) m_cycle = wd;
      else m_cycle = m_cycle + 32'd1;
      if (we && !is_io(addr)) begin
        m_ram[idx] = wd;
        m_vld[idx] = 1'b1;
      end
      if (pop) void'(m_q.pop_front());
      if (we && is_io(addr) && off == 1) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(wd);
        else m_ovf = 1'b1;
      end
      if (we && is_io(addr) && off == 2) m_ovf = 1'b0;
    end
    #1;
  endtask

  vec_t        vecs [15];
  obs_t        o;
  logic [31:0] offs [6];
  logic [31:0] exp_drain [$];

  initial begin
    reset          = 1'b1;
    WE             = 1'b0;
    address_to_mem = '0;
    data_to_mem    = '0;
    out_ready      = 1'b0;
    m_cycle        = '0;
    m_ovf          = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed table starting in the first cycle after reset release.
    vecs[0]  = '{1'b0, IO_BASE,          32'h0,         1'b1, 32'h0};
    vecs[1]  = '{1'b0, IO_BASE + 32'h4,  32'h0,         1'b1, 32'h0};
    vecs[2]  = '{1'b0, IO_BASE + 32'h8,  32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1'b0, IO_BASE,          32'h0,         1'b1, 32'h3};
    vecs[4]  = '{1'b1, 32'h10,           32'h1111_1111, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h10,           32'hDEAD_BEEF, 1'b1, 32'h1111_1111};
    vecs[6]  = '{1'b0, 32'h10,           32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 32'h14,           32'hAA,        1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h17,           32'h0,         1'b1, 32'hAA};
    vecs[9]  = '{1'b0, 32'h110,          32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, IO_BASE,          32'hFFFF_FFFE, 1'b1, 32'hA};
    vecs[11] = '{1'b0, IO_BASE,          32'h0,         1'b1, 32'hFFFF_FFFE};
    vecs[12] = '{1'b0, IO_BASE,          32'h0,         1'b1, 32'hFFFF_FFFF};
    vecs[13] = '{1'b0, IO_BASE,          32'h0,         1'b1, 32'h0};
    vecs[14] = '{1'b0, IO_BASE + 32'h40, 32'h0,         1'b1, 32'h0};
    for (int i = 0; i < 15; i++) begin
      do_cycle(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wd, 1'b0, o);
      if (vecs[i].chk) check($sformatf("vec%0d rdata", i), o.rd, vecs[i].exp_rd);
    end

    // Fill without a consumer: no bypass on the first push.
    do_cycle(1'b0, 1'b1, IO_BASE + 32'h4, 32'd1, 1'b0, o);
    check("push into empty valid", 32'(o.ov), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      do_cycle(1'b0, 1'b1, IO_BASE + 32'h4, i, 1'b0, o);
      check("fill valid", 32'(o.ov), 32'd1);
      check("fill head", o.od, 32'd1);
    end
    do_cycle(1'b0, 1'b0, IO_BASE + 32'h4, 32'h0, 1'b0, o);
    check("status full", o.rd, 32'h0000_0004);
    for (int i = 1; i <= 4; i++) begin
      do_cycle(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, o);
      check("drain head", o.od, i);
    end
    do_cycle(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, o);
    check("drained valid", 32'(o.ov), 32'd0);

    // Overflow, clear, then push into a full FIFO while popping.
    for (int i = 11; i <= 14; i++) do_cycle(1'b0, 1'b1, IO_BASE + 32'h4, i, 1'b0, o);
    do_cycle(1'b0, 1'b1, IO_BASE + 32'h4, 32'd5, 1'b0, o);
    check("overflow before drop", 32'(o.of), 32'd0);
    do_cycle(1'b0, 1'b0, IO_BASE + 32'h4, 32'h0, 1'b0, o);
    check("status overflow", o.rd, 32'h8000_0004);
    check("overflow flag", 32'(o.of), 32'd1);
    do_cycle(1'b0, 1'b1, IO_BASE + 32'h8, 32'h1234, 1'b0, o);
    do_cycle(1'b0, 1'b0, IO_BASE + 32'h8, 32'h0, 1'b0, o);
    check("overflow cleared", 32'(o.of), 32'd0);
    check("clr reads zero", o.rd, 32'h0);
    do_cycle(1'b0, 1'b1, IO_BASE + 32'h4, 32'd6, 1'b1, o);
    check("full push+pop head", o.od, 32'd11);
    do_cycle(1'b0, 1'b0, IO_BASE + 32'h4, 32'h0, 1'b0, o);
    check("status after push+pop", o.rd, 32'h0000_0004);
    exp_drain = '{32'd12, 32'd13, 32'd14, 32'd6};
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, o);
      check("drain after push+pop", o.od, exp_drain[i]);
    end
    do_cycle(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, o);
    check("empty after push+pop", 32'(o.ov), 32'd0);

    // Reset mid-operation, with a RAM write presented in the reset cycle.
    do_cycle(1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, o);
    for (int i = 7; i <= 9; i++) do_cycle(1'b0, 1'b1, IO_BASE + 32'h4, i, 1'b0, o);
    do_cycle(1'b0, 1'b1, IO_BASE, 32'd50, 1'b0, o);
    do_cycle(1'b0, 1'b0, IO_BASE, 32'h0, 1'b0, o);
    check("counter loaded", o.rd, 32'd50);
    do_cycle(1'b1, 1'b1, 32'h20, 32'h0000_0BAD, 1'b1, o);
    do_cycle(1'b0, 1'b0, IO_BASE, 32'h0, 1'b0, o);
    check("counter after reset", o.rd, 32'h0);
    check("valid after reset", 32'(o.ov), 32'd0);
    do_cycle(1'b0, 1'b0, IO_BASE + 32'h4, 32'h0, 1'b0, o);
    check("status after reset", o.rd, 32'h0);
    do_cycle(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, o);
    check("ram kept over reset", o.rd, 32'h1234_5678);

    // Unmapped MMIO write leaves RAM and FIFO alone.
    do_cycle(1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, 1'b0, o);
    do_cycle(1'b0, 1'b1, IO_BASE + 32'h40, 32'h5555_5555, 1'b0, o);
    do_cycle(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, o);
    check("unmapped write ram", o.rd, 32'h0BAD_F00D);
    do_cycle(1'b0, 1'b0, IO_BASE + 32'h4, 32'h0, 1'b0, o);
    check("unmapped write fifo", o.rd, 32'h0);

    // Random traffic against the model, RAM preloaded so every read is predictable.
    for (int i = 0; i < RAM_WORDS; i++) do_cycle(1'b0, 1'b1, i * 4, $urandom(), 1'b0, o);
    offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40, 32'hFC};
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 1) == 0) begin
        a = $urandom();
        if (is_io(a)) a = 32'h0;
      end else begin
        a = IO_BASE + offs[$urandom_range(0, 5)] + $urandom_range(0, 3);
      end
      do_cycle($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, a, $urandom(),
               $urandom_range(0, 2) == 0, o);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
